// File: rtl/echo_delay_pkg.sv
// -----------------------------------------------------------------------------
// echo_delay_pkg
//  Shared definitions for the echo/delay controller: FSM state encoding, echo
//  gain format (unsigned Q1.7) and a generic signed saturation helper.
// -----------------------------------------------------------------------------
package echo_delay_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_MIX  = 2'd2,
      ST_WR   = 2'd3
   } state_e;

   localparam int GAIN_FRAC  = 7;   // 128 = 1.0
   localparam int GAIN_WIDTH = 8;

   // Clamp a signed value to the range of a w-bit signed number (w <= 63).
   // The caller truncates the result to w bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
      min_v = ~max_v;                  // -2^(w-1)
      if (v > max_v)      return max_v;
      else if (v < min_v) return min_v;
      else                return v;
   endfunction

endpackage

// File: rtl/echo_mix.sv
// -----------------------------------------------------------------------------
// echo_mix
//  Combinational echo mixer: mix = sat(dry + (wet * gain) >>> GAIN_FRAC).
//  Ports:
//   dry_i    in  DATA_WIDTH  signed dry sample
//   wet_i    in  DATA_WIDTH  signed delayed sample from the delay line
//   gain_i   in  GAIN_WIDTH  unsigned Q1.7 echo gain
//   wet_en_i in  1           0 forces the delayed term to zero
//   mix_o    out DATA_WIDTH  saturated signed result
// -----------------------------------------------------------------------------
module echo_mix
   import echo_delay_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic signed [DATA_WIDTH-1:0] dry_i,
   input  logic signed [DATA_WIDTH-1:0] wet_i,
   input  logic        [GAIN_WIDTH-1:0] gain_i,
   input  logic                         wet_en_i,
   output logic signed [DATA_WIDTH-1:0] mix_o
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam int SW = DATA_WIDTH + 2;

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] scaled;
   logic signed [SW-1:0] sum;
   logic signed [63:0]   sat;

   always_comb begin
      // Gain is zero-extended so it stays non-negative in the signed product.
      prod   = PW'(wet_i) * PW'($signed({1'b0, gain_i}));
      scaled = prod >>> GAIN_FRAC;
      if (!wet_en_i) scaled = '0;
      // |scaled| < 2^(DATA_WIDTH), so DATA_WIDTH+2 bits hold dry+scaled exactly.
      sum    = SW'(dry_i) + SW'(scaled);
      sat    = saturate(64'(sum), DATA_WIDTH);
      mix_o  = DATA_WIDTH'(sat);
   end

endmodule

// File: rtl/echo_delay_ctrl.sv
// -----------------------------------------------------------------------------
// echo_delay_ctrl
//  Echo/delay controller driving a dual-port memory used as a circular delay
//  line. Per accepted sample: read the sample written DELAY samples earlier
//  (port 2), write the new sample (port 1), emit dry + GAIN*delayed, saturated.
//  Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   IN_VALID/IN_READY   input handshake (ready only in IDLE)
//   IN_DATA             signed dry sample
//   DELAY               delay in samples 0..SIZE (larger values clamp to SIZE)
//   GAIN                unsigned Q1.7 echo gain
//   OUT_VALID/OUT_DATA  one-cycle result pulse and signed wet sample
//   WE/ADDR1/DI         memory write port
//   ADDR2/DO2           memory read port (DO2 valid one cycle after ADDR2)
// -----------------------------------------------------------------------------
module echo_delay_ctrl
   import echo_delay_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3,
   parameter int SIZE       = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic [ADDR_WIDTH:0]   DELAY,
   input  logic [GAIN_WIDTH-1:0] GAIN,
   output logic                  OUT_VALID,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic                  WE,
   output logic [ADDR_WIDTH-1:0] ADDR1,
   output logic [DATA_WIDTH-1:0] DI,
   output logic [ADDR_WIDTH-1:0] ADDR2,
   input  logic [DATA_WIDTH-1:0] DO2
);

   localparam logic [ADDR_WIDTH:0]   SIZE_C  = (ADDR_WIDTH+1)'(SIZE);
   localparam logic [ADDR_WIDTH:0]   FILL_1  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_1   = ADDR_WIDTH'(1);

   state_e                  state_q, state_d;
   logic                    rdy_q, rdy_d;
   logic                    ov_q, ov_d;
   logic [DATA_WIDTH-1:0]   out_q, out_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
   logic [DATA_WIDTH-1:0]   di_q, di_d;
   logic [ADDR_WIDTH-1:0]   addr2_q, addr2_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]     fill_q, fill_d;
   logic [DATA_WIDTH-1:0]   smp_q, smp_d;
   logic [ADDR_WIDTH:0]     dly_q, dly_d;
   logic [GAIN_WIDTH-1:0]   gain_q, gain_d;

   logic [ADDR_WIDTH:0]     dly_clamp;
   logic                    wet_en;
   logic [DATA_WIDTH-1:0]   mix_res;

   assign dly_clamp = (DELAY > SIZE_C) ? SIZE_C : DELAY;

   // A zero delay is a dry bypass; until DELAY samples have been written the
   // addressed slot holds stale data from before reset and must not be mixed.
   assign wet_en = (dly_q != '0) && (fill_q >= dly_q);

   echo_mix #(.DATA_WIDTH(DATA_WIDTH)) u_mix (
      .dry_i    (smp_q),
      .wet_i    (DO2),
      .gain_i   (gain_q),
      .wet_en_i (wet_en),
      .mix_o    (mix_res)
   );

   always_comb begin
      state_d  = state_q;
      rdy_d    = rdy_q;
      ov_d     = ov_q;
      out_d    = out_q;
      we_d     = we_q;
      addr1_d  = addr1_q;
      di_d     = di_q;
      addr2_d  = addr2_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      smp_d    = smp_q;
      dly_d    = dly_q;
      gain_d   = gain_q;
      case (state_q)
         ST_IDLE: begin
            if (IN_VALID && rdy_q) begin
               smp_d   = IN_DATA;
               dly_d   = dly_clamp;
               gain_d  = GAIN;
               // SIZE is a power of two, so the truncated subtraction wraps
               // modulo SIZE; DELAY=SIZE lands on wr_ptr itself.
               addr2_d = wr_ptr_q - dly_clamp[ADDR_WIDTH-1:0];
               rdy_d   = 1'b0;
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            state_d = ST_MIX;
         end
         ST_MIX: begin
            out_d   = mix_res;
            ov_d    = 1'b1;
            addr1_d = wr_ptr_q;
            di_d    = smp_q;
            we_d    = 1'b1;
            state_d = ST_WR;
         end
         ST_WR: begin
            ov_d     = 1'b0;
            we_d     = 1'b0;
            wr_ptr_d = wr_ptr_q + PTR_1;
            fill_d   = (fill_q == SIZE_C) ? fill_q : fill_q + FILL_1;
            rdy_d    = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            rdy_d   = 1'b1;
            ov_d    = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         rdy_q    <= 1'b1;
         ov_q     <= 1'b0;
         out_q    <= '0;
         we_q     <= 1'b0;
         addr1_q  <= '0;
         di_q     <= '0;
         addr2_q  <= '0;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         smp_q    <= '0;
         dly_q    <= '0;
         gain_q   <= '0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         ov_q     <= ov_d;
         out_q    <= out_d;
         we_q     <= we_d;
         addr1_q  <= addr1_d;
         di_q     <= di_d;
         addr2_q  <= addr2_d;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         smp_q    <= smp_d;
         dly_q    <= dly_d;
         gain_q   <= gain_d;
      end
   end

   assign IN_READY  = rdy_q;
   assign OUT_VALID = ov_q;
   assign OUT_DATA  = out_q;
   assign WE        = we_q;
   assign ADDR1     = addr1_q;
   assign DI        = di_q;
   assign ADDR2     = addr2_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_echo_delay_ctrl
//  Bench for echo_delay_ctrl with a behavioural dual-port memory. A reference
//  model keeps the history of written samples since reset and derives every
//  result from the mixing rule with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_echo_delay_ctrl;

   localparam int DW = 32;
   localparam int AW = 3;
   localparam int SZ = 8;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          IN_VALID = 1'b0;
   logic [DW-1:0] IN_DATA = '0;
   logic [AW:0]   DELAY = '0;
   logic [7:0]    GAIN = '0;
   logic          IN_READY, OUT_VALID, WE;
   logic [DW-1:0] OUT_DATA, DI, DO2;
   logic [AW-1:0] ADDR1, ADDR2;

   always #5 CLK = ~CLK;

   echo_delay_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_DATA(IN_DATA), .DELAY(DELAY), .GAIN(GAIN), .OUT_VALID(OUT_VALID),
      .OUT_DATA(OUT_DATA), .WE(WE), .ADDR1(ADDR1), .DI(DI), .ADDR2(ADDR2),
      .DO2(DO2)
   );

   // dual-port memory: registered read, write on WE
   logic [DW-1:0] mem [SZ];
   always @(posedge CLK) begin
      if (WE) mem[ADDR1] <= DI;
      DO2 <= mem[ADDR2];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mix_model(input longint dry, input longint wet,
                                                input longint g);
      longint s;
      s = dry + ((wet * g) >>> 7);
      if (s > 64'sd2147483647)       s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
      return s[DW-1:0];
   endfunction

   // ---------------- reference model (updated at each rising edge) -----------
   int            since = 0;      // cycles since the accept edge, 0 = idle
   int            wr_cnt = 0;     // samples written since reset
   longint        hist[$];        // written samples, oldest first
   logic          model_ok = 1'b0;
   logic          in_rst = 1'b1;
   logic          exp_rdy = 1'b1, exp_ov = 1'b0, exp_we = 1'b0;
   logic [DW-1:0] exp_out = '0, exp_di = '0, pend_res = '0, pend_smp = '0;
   logic [AW-1:0] exp_a1 = '0, exp_a2 = '0;
   logic [DW-1:0] mres[$];        // model results, in accept order
   logic [DW-1:0] got[$];         // DUT results, in output order

   initial begin
      forever begin
         @(posedge CLK);
         model_ok = 1'b1;
         if (!RST_N) begin
            since = 0; wr_cnt = 0; hist.delete();
            exp_rdy = 1'b1; exp_ov = 1'b0; exp_we = 1'b0; exp_out = '0;
            exp_a1 = '0; exp_a2 = '0; exp_di = '0; in_rst = 1'b1;
         end else begin
            in_rst = 1'b0;
            if (since == 0) begin
               if (IN_VALID) begin
                  int d;
                  longint wet;
                  d   = (DELAY > 4'd8) ? 8 : int'(DELAY);
                  wet = (d != 0 && hist.size() >= d) ? hist[hist.size() - d] : 0;
                  pend_res = mix_model(longint'($signed(IN_DATA)), wet, longint'(GAIN));
                  mres.push_back(pend_res);
                  pend_smp = IN_DATA;
                  exp_a2   = AW'(((wr_cnt - d) % SZ + SZ) % SZ);
                  exp_rdy  = 1'b0;
                  since    = 1;
               end
            end else if (since == 1) begin
               since = 2;
            end else if (since == 2) begin
               since = 3; exp_ov = 1'b1; exp_we = 1'b1; exp_out = pend_res;
               exp_a1 = AW'(wr_cnt % SZ); exp_di = pend_smp;
            end else begin
               since = 0; exp_ov = 1'b0; exp_we = 1'b0; exp_rdy = 1'b1;
               hist.push_back(longint'($signed(pend_smp)));
               if (hist.size() > SZ) void'(hist.pop_front());
               wr_cnt++;
            end
         end
      end
   end

   // ---------------- per-cycle compare (falling edge) -------------------------
   initial begin
      forever begin
         @(negedge CLK);
         if (model_ok) begin
            chk("in_ready", IN_READY, exp_rdy);
            chk("out_valid", OUT_VALID, exp_ov);
            chk("we", WE, exp_we);
            if (exp_ov) chk("out_data", OUT_DATA, exp_out);
            if (exp_we) begin
               chk("addr1", ADDR1, exp_a1);
               chk("di", DI, exp_di);
            end
            if (since == 1 || since == 2) chk("addr2", ADDR2, exp_a2);
            if (in_rst) begin
               chk("rst_out_data", OUT_DATA, 0);
               chk("rst_addr1", ADDR1, 0);
               chk("rst_addr2", ADDR2, 0);
               chk("rst_di", DI, 0);
            end
            if (OUT_VALID === 1'b1) got.push_back(OUT_DATA);
         end
      end
   end

   // ---------------- stimulus --------------------------------------------------
   task automatic do_reset(input int n);
      @(negedge CLK);
      RST_N = 1'b0; IN_VALID = 1'b0;
      repeat (n) @(negedge CLK);
      RST_N = 1'b1;
      mres.delete(); got.delete();
   endtask

   task automatic send(input logic [DW-1:0] data, input logic [AW:0] d, input logic [7:0] g);
      int w = 0;
      @(negedge CLK);
      while (!exp_rdy && w < 40) begin
         @(negedge CLK);
         w++;
      end
      if (w >= 40) chk("ready_timeout", 0, 1);
      IN_DATA = data; DELAY = d; GAIN = g; IN_VALID = 1'b1;
      @(negedge CLK);
      // later DELAY/GAIN changes must not affect the accepted sample
      IN_VALID = 1'b0; DELAY = 4'($urandom()); GAIN = 8'($urandom());
   endtask

   task automatic check_seq(input string name, input logic [DW-1:0] lits[$]);
      repeat (6) @(negedge CLK);
      chk({name, "_count"}, got.size(), lits.size());
      foreach (lits[i]) begin
         chk({name, "_model"}, (i < mres.size()) ? mres[i] : 'x, lits[i]);
         chk({name, "_dut"}, (i < got.size()) ? got[i] : 'x, lits[i]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] lits[$];
      int w;

      // reset held 3 clocks; IN_READY=1 and zeroed outputs checked per cycle
      do_reset(3);

      // DELAY=2 gain 1.0
      send(10, 2, 128); send(20, 2, 128); send(30, 2, 128);
      lits = '{32'd10, 32'd20, 32'd40};
      check_seq("d2", lits);

      // DELAY=1 gain 0.5, then dry bypass
      do_reset(3);
      send(100, 1, 64); send(200, 1, 64); send(7, 0, 200);
      lits = '{32'd100, 32'd250, 32'd7};
      check_seq("d1", lits);

      // saturation both ways
      do_reset(3);
      send(32'h7FFFFFF0, 1, 128); send(32'h7FFFFFF0, 1, 128);
      send(32'h80000010, 1, 128); send(32'h80000010, 1, 128);
      lits = '{32'h7FFFFFF0, 32'h7FFFFFFF, 32'h00000000, 32'h80000000};
      check_seq("sat", lits);

      // full-depth delay with pointer wrap; DELAY=15 clamps to 8
      do_reset(3);
      for (int i = 1; i <= 9; i++) send(DW'(i), (i == 9) ? 4'd15 : 4'd8, 128);
      lits = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd10};
      check_seq("d8", lits);

      // continuous IN_VALID: one accept per 4 clocks (IN_READY checked per cycle)
      @(negedge CLK);
      IN_VALID = 1'b1;
      for (int i = 0; i < 40; i++) begin
         IN_DATA = $urandom(); DELAY = 4'($urandom_range(0, 9)); GAIN = 8'($urandom());
         @(negedge CLK);
      end
      IN_VALID = 1'b0;

      // reset while in WR: WE drops next cycle, next output is dry
      send(32'd99, 1, 128);
      w = 0;
      while (since != 3 && w < 20) begin
         @(negedge CLK);
         w++;
      end
      if (w >= 20) chk("wr_wait_timeout", 0, 1);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      mres.delete(); got.delete();
      send(55, 1, 128);
      lits = '{32'd55};
      check_seq("rst_wr", lits);

      // randomized traffic with occasional resets
      for (int i = 0; i < 200; i++) begin
         logic [DW-1:0] dv;
         case ($urandom_range(0, 3))
            0: dv = 32'h7FFF0000 + DW'($urandom_range(0, 65535));
            1: dv = 32'h80000000 + DW'($urandom_range(0, 65535));
            default: dv = $urandom();
         endcase
         send(dv, 4'($urandom_range(0, 15)), 8'($urandom()));
         if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 3));
      end
      repeat (8) @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
